// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch front end
//
// Contents:
//   XLEN, ILEN        address and instruction widths (16)
//   PC_STEP           byte distance between consecutive instructions
//   fetch_state_e     sequencer state encoding (IDLE=0, FETCH=1, HALT=2)
package cpu_pkg;

    localparam int XLEN = 16;
    localparam int ILEN = 16;
    localparam logic [XLEN-1:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer holding {pc, ins} pairs
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_pc/ins     write an entry at the tail
//   pop                   remove the head (ignored when empty)
//   flush                 empty the buffer; wins over push and pop
//   count                 number of valid entries (0..DEPTH)
//   head_pc, head_ins     oldest entry; storage is zeroed by reset
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [ILEN-1:0] push_ins,
    input  logic            pop,
    input  logic            flush,
    output logic [CW-1:0]   count,
    output logic [XLEN-1:0] head_pc,
    output logic [ILEN-1:0] head_ins
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] mem_pc  [DEPTH];
    logic [ILEN-1:0] mem_ins [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic            do_pop;
    logic            do_push;

    assign do_pop  = pop && (count != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count < DEPTH_C) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]  <= '0;
                mem_ins[i] <= '0;
            end
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem_pc[wp]  <= push_pc;
                mem_ins[wp] <= push_ins;
                wp          <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_pc  = mem_pc[rp];
    assign head_ins = mem_ins[rp];

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner, instruction fetch and issue to decode
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_pc / imem_ins       combinational instruction memory read port
//   redirect_valid/_pc       one-cycle flush and restart at a new PC
//   halt                     level; stops new fetches while high
//   out_valid/ready/ins/pc   issue handshake toward decode
//   halted                   sequencer is in HALT
//   misaligned               only with FETCH_ALIGN_CHK_EN: odd redirect target seen
//
// Build option FETCH_ALIGN_CHK_EN adds the misaligned flag, which blocks fetch
// until a redirect with an even target arrives.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 16'h0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_pc,
    input  logic [ILEN-1:0] imem_ins,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_ins,
    output logic [XLEN-1:0] out_pc,
    output logic            halted
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic            misaligned
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   count;
    logic            pop;
    logic            push;
    logic            align_block;

    assign pop = out_valid && out_ready;

    // Redirect wins: the same-cycle pop is discarded by the buffer flush.
    assign push = (state == ST_FETCH) && !halt && !redirect_valid && !align_block
                  && ((count < DEPTH_C) || pop);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = halt ? ST_HALT : ST_FETCH;
            ST_FETCH: state_nxt = halt ? ST_HALT : ST_FETCH;
            ST_HALT:  state_nxt = halt ? ST_HALT : ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (push) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned <= 1'b0;
        end else if (redirect_valid) begin
            misaligned <= redirect_pc[0];
        end
    end
    assign align_block = misaligned;
`else
    assign align_block = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_pc  (fetch_pc),
        .push_ins (imem_ins),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (count),
        .head_pc  (out_pc),
        .head_ins (out_ins)
    );

    assign imem_pc   = fetch_pc;
    assign out_valid = (count != '0);
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] imem_pc;
    logic [15:0] imem_ins;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ins;
    logic [15:0] out_pc;
    logic        halted;
`ifdef FETCH_ALIGN_CHK_EN
    logic        misaligned;
`endif

    int          checks;
    int          errors;
    int          pops;
    bit          done;
    logic [31:0] exp_q[$];

    fetch_sequencer #(
        .RESET_PC (16'h0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_ins       (imem_ins),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .halted         (halted)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .misaligned     (misaligned)
`endif
    );

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    assign imem_ins = mem_f(imem_pc);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected issue order after a (re)start: consecutive PCs from the start address.
    task automatic set_stream(input logic [15:0] start);
        logic [15:0] p;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back({p, mem_f(p)});
            p = p + 16'd2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic monitor();
        logic [31:0] e;
        while (!done) begin
            @(negedge clk);
            if (!rst && out_valid && out_ready && !redirect_valid) begin
                pops++;
                if (exp_q.size() == 0) begin
                    chk("stream_empty", {out_pc, out_ins}, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_pc", {16'h0, out_pc}, {16'h0, e[31:16]});
                    chk("stream_ins", {16'h0, out_ins}, {16'h0, e[15:0]});
                end
            end
        end
    endtask

    task automatic redirect_to(input logic [15:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        set_stream(target);
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic stimulus();
        rst            = 1'b1;
        out_ready      = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        set_stream(16'h0000);
        ticks(3);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_imem_pc", {16'h0, imem_pc}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_out_pc", {16'h0, out_pc}, 32'h0);
        chk("rst_out_ins", {16'h0, out_ins}, 32'h0);

        // Release: IDLE one cycle, first issue two cycles after release.
        rst = 1'b0;
        tick();
        chk("start_valid_c1", {31'h0, out_valid}, 32'h0);
        tick();
        chk("start_valid_c2", {31'h0, out_valid}, 32'h1);
        chk("start_pc_c2", {16'h0, out_pc}, 32'h0);
        ticks(8);

        // Fill the buffer, then redirect while full.
        out_ready = 1'b0;
        ticks(3);
        chk("full_valid", {31'h0, out_valid}, 32'h1);
        redirect_to(16'h0040);
        out_ready = 1'b1;
        chk("redir_valid_n1", {31'h0, out_valid}, 32'h0);
        tick();
        chk("redir_valid_n2", {31'h0, out_valid}, 32'h1);
        chk("redir_pc_n2", {16'h0, out_pc}, 32'h0040);
        ticks(4);

        // Asynchronous reset between edges, then backpressure from a fresh start.
        @(posedge clk);
        #3;
        rst       = 1'b1;
        out_ready = 1'b0;
        set_stream(16'h0000);
        #1;
        chk("async_out_valid", {31'h0, out_valid}, 32'h0);
        chk("async_imem_pc", {16'h0, imem_pc}, 32'h0);
        chk("async_halted", {31'h0, halted}, 32'h0);
        tick();
        rst = 1'b0;
        ticks(5);
        chk("bp_valid", {31'h0, out_valid}, 32'h1);
        chk("bp_head_pc", {16'h0, out_pc}, 32'h0);
        chk("bp_head_ins", {16'h0, out_ins}, {16'h0, mem_f(16'h0)});
        chk("bp_fetch_pc", {16'h0, imem_pc}, 32'h4);
        out_ready = 1'b1;
        ticks(3);

        // Halt for four cycles; buffer drains and fetch resumes in order.
        halt = 1'b1;
        tick();
        chk("halt_halted", {31'h0, halted}, 32'h1);
        ticks(3);
        chk("halt_drained", {31'h0, out_valid}, 32'h0);
        halt = 1'b0;
        tick();
        chk("halt_release", {31'h0, halted}, 32'h0);
        ticks(6);

        // PC wrap at the top of the address space.
        redirect_to(16'hFFFC);
        chk("wrap_valid_n1", {31'h0, out_valid}, 32'h0);
        tick();
        chk("wrap_pc_n2", {16'h0, out_pc}, 32'hFFFC);
        ticks(5);

`ifdef FETCH_ALIGN_CHK_EN
        redirect_to(16'h0013);
        exp_q.delete();
        ticks(4);
        chk("mis_flag", {31'h0, misaligned}, 32'h1);
        chk("mis_blocked", {31'h0, out_valid}, 32'h0);
        redirect_to(16'h0100);
        chk("mis_clear", {31'h0, misaligned}, 32'h0);
        ticks(4);
`endif

        // Randomized traffic with backpressure, halts and redirects.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) halt = ~halt;
            if ($urandom_range(29) == 0) begin
                redirect_to(16'($urandom_range(16'hFFFF)) & 16'hFFFE);
            end else begin
                tick();
            end
        end
        halt      = 1'b0;
        out_ready = 1'b1;
        ticks(6);
        chk("pops_seen", {31'h0, (pops > 100)}, 32'h1);
        done = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pops   = 0;
        done   = 1'b0;
        fork
            monitor();
            stimulus();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch sequencer that owns the program counter and drives the combinational `instructionMemory` read port (`pc` in, `ins` out, byte addresses, 16-bit instructions at even addresses). It walks the PC in steps of 2, captures each instruction with its PC into a small prefetch buffer, and hands entries to the decode stage over a valid/ready handshake. It also handles branch/jump redirects and a halt request.

## Interface
- `RESET_PC`, 16'h0000, PC loaded at reset and the first fetch address.
- `DEPTH`, 2, prefetch buffer entries (power of two, 2..8).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_pc`  out  16  address to instruction memory. Equals the `fetch_pc` register.
- `imem_ins`  in  16  instruction memory read data, valid in the same cycle.
- `redirect_valid`  in  1  one-cycle pulse: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  16  redirect target.
- `halt`  in  1  level: while high, no new fetches are pushed.
- `out_valid`  out  1  buffer head is valid.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_ins`  out  16  head instruction.
- `out_pc`  out  16  head PC.
- `halted`  out  1  state is HALT.

## Operation
- Registers:
  - `fetch_pc` (16b).
  - FIFO of DEPTH × {pc, ins}, with read and write pointers (log2(DEPTH) bits, wrapping).
  - `count` (0..DEPTH).
  - 2-bit state.
- States:
  - **IDLE**: entered on reset. No push. Always moves to FETCH next cycle, unless `halt` is high, in which case it moves to HALT.
  - **FETCH**: pushes {`fetch_pc`, `imem_ins`} when push is enabled (defined below); on a push, `fetch_pc` += 2. Moves to HALT when `halt` is high.
  - **HALT**: no push. Moves back to FETCH when `halt` is low.
- Pop: `out_valid && out_ready` removes the head.
- Push enable: state == FETCH, `!halt`, `!redirect_valid`, and (`count < DEPTH` or pop this cycle). Simultaneous push and pop at full is allowed, so `count` is unchanged.
- Redirect has the highest priority and applies in any state:
  - `count` ← 0 and both pointers ← 0.
  - `fetch_pc` ← `redirect_pc`.
  - Any pop in the same cycle is discarded. State is unchanged.
- Arithmetic: `fetch_pc + 2` is modulo 2^16, so 16'hFFFE wraps to 16'h0000 with no flag.
- `out_valid = (count != 0)`. `out_ins`/`out_pc` are driven from the FIFO head and are don't-care while `out_valid` is low.
- A `redirect_pc` with bit 0 set is not corrected. It is used as given (see Configuration).

## Timing
- Reset values:
  - `fetch_pc` = RESET_PC, `imem_pc` = RESET_PC.
  - `count` = 0, `out_valid` = 0, `halted` = 0.
  - `out_ins` = 0, `out_pc` = 0 (storage cleared).
  - state = IDLE.
- After reset release: IDLE for 1 cycle. The first push occurs at the end of the next cycle, and `out_valid` rises 2 cycles after reset release.
- Steady state with `out_ready` held high: one instruction per cycle, with consecutive `out_pc` values 2 apart.
- Redirect pulse in cycle N:
  - `out_valid` = 0 in cycle N+1.
  - The target instruction is presented in cycle N+2 (redirect-to-issue latency 2).
- Halt:
  - `halted` rises the cycle after `halt` is sampled high.
  - Buffered entries still drain while halted.
  - Fetch resumes at the preserved `fetch_pc` with no skipped or duplicated PC.
- Holding `out_ready` low keeps head data stable until it is accepted.
- Reset asserted mid-operation clears everything immediately (asynchronously). In-flight entries are lost.

## Configuration
- `FETCH_ALIGN_CHK_EN`:
  - **Defined:** adds output `misaligned` (1b, reset 0), which is set on a redirect whose `redirect_pc[0]` == 1. While it is set, pushes are blocked. It is cleared by the next redirect with an even target or by reset.
  - **Undefined:** there is no `misaligned` port, and an odd target is fetched as given.

## Structure
- Shared package `cpu_pkg`:
  - State encoding (IDLE=0, FETCH=1, HALT=2).
  - `PC_STEP` = 2.
  - Instruction and address width constants (16).
- Sub-module `fetch_fifo`: a parameterised synchronous FIFO with push, pop, flush, count, and head outputs. The sequencer holds the FSM, PC logic and push/redirect priority.

## Test plan
- **Reset and stream:** `rst` high for 3 cycles, then low, with `out_ready` = 1.
  - `out_pc` sequence is 0,2,4,…,14, starting 2 cycles after release.
  - `out_ins` matches memory contents.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles.
  - `count` saturates at 2 and the head is held at pc 0.
  - After release, pcs 0,2,4 follow with no gap or duplicate.
- **Redirect:** pulse `redirect_valid` with `redirect_pc` = 16'h0040 while the buffer is full.
  - `out_valid` = 0 in the next cycle.
  - `out_pc` = 16'h0040 two cycles after the pulse, then 16'h0042.
- **Halt:** raise `halt` at pc 6 for 4 cycles.
  - Buffered entries drain and `halted` = 1.
  - After `halt` is released, `out_pc` resumes at the next unfetched pc without a repeat.
- **Wrap:** redirect to 16'hFFFC.
  - `out_pc` sequence is FFFC, FFFE, 0000, 0002.
- **Reset mid-stream:** assert `rst` asynchronously between edges.
  - `out_valid` drops immediately and `imem_pc` = RESET_PC.
  - With `FETCH_ALIGN_CHK_EN` defined, a redirect to 16'h0013 sets `misaligned` and blocks pushes.
